// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the processor (master) and the data memory
// responder (slave): a valid/ready request channel and a valid/ready
// response channel.
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store word, 0 = load word
//   req_addr            : byte address, alignment not required
//   req_wdata           : store data, MSB byte goes to the lowest address
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores and errors)
//   rsp_err             : address out of range, access suppressed
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory serving the processor's load/store port with a
// programmable access latency. One transaction in flight at a time.
// Word byte order is MSB first: word(A) = {mem[A], mem[A+1], mem[A+2], mem[A+3]},
// with byte addresses wrapping modulo 2**ADDR_W.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (memory contents are not reset)
//   bus   : data_mem_if slave modport (request and response channels)
// Parameters:
//   ADDR_W  : implemented address bits, array holds 2**ADDR_W bytes
//   LATENCY : wait cycles between accept and response, 0..15
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input logic      clk,
  input logic      rst_n,
  data_mem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              write_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [7:0]        mem [0:(1 << ADDR_W) - 1];

  logic              accept;
  logic              addr_err;
  logic              commit;
  logic [ADDR_W-1:0] byte_addr [4];

  assign bus.req_ready = rst_n && (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign addr_err = (bus.req_addr >> ADDR_W) != '0;

  // The counter runs LATENCY..0 and the access happens on the edge that
  // leaves WAIT with the count at 0. This gives the same timing as counting
  // down to 1 and still routes LATENCY=0 through one cycle of WAIT, so
  // rsp_valid always rises after edge LATENCY+1.
  assign commit = (state == WAIT) && (wait_cnt == '0);

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + ADDR_W'(k);
    end
  end

  // Memory array is not reset; a store lands on the edge that enters RESP,
  // so a reset while waiting drops the store.
  always_ff @(posedge clk) begin
    if (commit && write_q && !err_q) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem[byte_addr[k]] <= wdata_q[31 - 8*k -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q  <= bus.req_write;
            addr_q   <= bus.req_addr[ADDR_W-1:0];
            wdata_q  <= bus.req_wdata;
            err_q    <= addr_err;
            wait_cnt <= LAT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            if (write_q || err_q) begin
              rsp_rdata_q <= '0;
            end else begin
              rsp_rdata_q <= {mem[byte_addr[0]], mem[byte_addr[1]],
                              mem[byte_addr[2]], mem[byte_addr[3]]};
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Backdoor access to the array; both use address[ADDR_W-1:0].
  task automatic read_memory_byte(input logic [31:0] address, output logic [7:0] data);
    data = mem[address[ADDR_W-1:0]];
  endtask

  task automatic write_memory_byte(input logic [31:0] address, input logic [7:0] data);
    mem[address[ADDR_W-1:0]] <= data;
  endtask

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: one instance with
// LATENCY=2 for the main transaction tests and one with LATENCY=0 for the
// back-to-back throughput test.
module tb_data_mem_responder;

  logic clk;
  logic rst_n;

  data_mem_if if0 ();
  data_mem_if if1 ();

  data_mem_responder #(.ADDR_W(16), .LATENCY(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  data_mem_responder #(.ADDR_W(16), .LATENCY(0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction on the LATENCY=2 instance. Returns the response
  // and the number of edges from the accept edge to rsp_valid being seen.
  task automatic txn0(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int edges);
    int n;
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_write = wr;
    if0.req_addr  = addr;
    if0.req_wdata = wd;
    n = 0;
    while (!if0.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Post-accept changes must have no effect.
    if0.req_valid = 1'b0;
    if0.req_write = ~wr;
    if0.req_addr  = 32'h0000_0000;
    if0.req_wdata = 32'hFFFF_FFFF;
    edges = 0;
    while (!if0.rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    rd = if0.rsp_rdata;
    er = if0.rsp_err;
    if0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          edges;
  logic [7:0]  b;
  logic [7:0]  pre [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0; if0.req_wdata = '0; if0.rsp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0; if1.req_wdata = '0; if1.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(if0.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("rst_rsp_rdata", if0.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(if0.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(if0.req_ready), 32'd1);

    // 1. store then load at 0x0050
    txn0(1'b1, 32'h0000_0050, 32'hDEAD_BEEF, rd, er, edges);
    check("t1_st_latency", 32'(edges), 32'd3);
    check("t1_st_err",     32'(er), 32'd0);
    check("t1_st_rdata",   rd, 32'd0);
    check("t1_post_valid", 32'(if0.rsp_valid), 32'd0);
    u_dut0.read_memory_byte(32'h50, b); check("t1_mem50", 32'(b), 32'hDE);
    u_dut0.read_memory_byte(32'h51, b); check("t1_mem51", 32'(b), 32'hAD);
    u_dut0.read_memory_byte(32'h52, b); check("t1_mem52", 32'(b), 32'hBE);
    u_dut0.read_memory_byte(32'h53, b); check("t1_mem53", 32'(b), 32'hEF);
    txn0(1'b0, 32'h0000_0050, 32'h0, rd, er, edges);
    check("t1_ld_latency", 32'(edges), 32'd3);
    check("t1_ld_rdata",   rd, 32'hDEAD_BEEF);
    check("t1_ld_err",     32'(er), 32'd0);

    // 2. store across the top of memory
    txn0(1'b1, 32'h0000_FFFE, 32'h1122_3344, rd, er, edges);
    check("t2_st_err", 32'(er), 32'd0);
    u_dut0.read_memory_byte(32'hFFFE, b); check("t2_memFFFE", 32'(b), 32'h11);
    u_dut0.read_memory_byte(32'hFFFF, b); check("t2_memFFFF", 32'(b), 32'h22);
    u_dut0.read_memory_byte(32'h0000, b); check("t2_mem0000", 32'(b), 32'h33);
    u_dut0.read_memory_byte(32'h0001, b); check("t2_mem0001", 32'(b), 32'h44);
    txn0(1'b0, 32'h0000_FFFE, 32'h0, rd, er, edges);
    check("t2_ld_rdata", rd, 32'h1122_3344);

    // 3. out-of-range accesses
    @(negedge clk);
    u_dut0.write_memory_byte(32'h2, 8'h55);
    u_dut0.write_memory_byte(32'h3, 8'h66);
    @(negedge clk);
    txn0(1'b0, 32'h0001_0000, 32'h0, rd, er, edges);
    check("t3_ld_err",     32'(er), 32'd1);
    check("t3_ld_rdata",   rd, 32'd0);
    check("t3_ld_latency", 32'(edges), 32'd3);
    txn0(1'b1, 32'h0001_0000, 32'hAABB_CCDD, rd, er, edges);
    check("t3_st_err",   32'(er), 32'd1);
    check("t3_st_rdata", rd, 32'd0);
    u_dut0.read_memory_byte(32'h0, b); check("t3_mem0", 32'(b), 32'h33);
    u_dut0.read_memory_byte(32'h1, b); check("t3_mem1", 32'(b), 32'h44);
    u_dut0.read_memory_byte(32'h2, b); check("t3_mem2", 32'(b), 32'h55);
    u_dut0.read_memory_byte(32'h3, b); check("t3_mem3", 32'(b), 32'h66);

    // 4. response backpressure with a second request pending
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_write = 1'b0;
    if0.req_addr  = 32'h0000_0050;
    @(posedge clk);
    #1;
    if0.req_addr = 32'h0000_FFFE;
    edges = 0;
    while (!if0.rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("t4_latency", 32'(edges), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(if0.rsp_valid), 32'd1);
      check("t4_hold_rdata", if0.rsp_rdata, 32'hDEAD_BEEF);
      check("t4_hold_err",   32'(if0.rsp_err), 32'd0);
      check("t4_hold_ready", 32'(if0.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("t4_still_valid", 32'(if0.rsp_valid), 32'd1);
    if0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.rsp_ready = 1'b0;
    check("t4_hs_valid", 32'(if0.rsp_valid), 32'd0);
    check("t4_hs_ready", 32'(if0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("t4_second_acc", 32'(if0.req_ready), 32'd0);
    if0.req_valid = 1'b0;
    edges = 0;
    while (!if0.rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("t4_second_rdata", if0.rsp_rdata, 32'h1122_3344);
    if0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.rsp_ready = 1'b0;

    // 5. reset while a store is waiting
    for (int k = 0; k < 4; k++) u_dut0.read_memory_byte(32'h100 + 32'(k), pre[k]);
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_write = 1'b1;
    if0.req_addr  = 32'h0000_0100;
    if0.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    if0.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(if0.rsp_valid), 32'd0);
    check("t5_rst_ready", 32'(if0.req_ready), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_rel_ready", 32'(if0.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      u_dut0.read_memory_byte(32'h100 + 32'(k), b);
      check("t5_mem_kept", 32'(b), 32'(pre[k]));
    end

    // 6. LATENCY=0 back-to-back loads
    @(negedge clk);
    u_dut1.write_memory_byte(32'h20, 8'h01);
    u_dut1.write_memory_byte(32'h21, 8'h02);
    u_dut1.write_memory_byte(32'h22, 8'h03);
    u_dut1.write_memory_byte(32'h23, 8'h04);
    @(negedge clk);
    if1.req_valid = 1'b1;
    if1.req_write = 1'b0;
    if1.req_addr  = 32'h0000_0020;
    if1.rsp_ready = 1'b1;
    for (int e = 0; e < 9; e++) begin
      check("t6_req_ready", 32'(if1.req_ready), ((e % 3) == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      check("t6_rsp_valid", 32'(if1.rsp_valid), ((e % 3) == 1) ? 32'd1 : 32'd0);
      if ((e % 3) == 1) check("t6_rsp_rdata", if1.rsp_rdata, 32'h0102_0304);
      @(negedge clk);
    end
    if1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    if1.rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
